// File: rtl/ifetch_icache_if.sv
// ifetch_icache_if: word-refill handshake between the fetch cache and instruction memory.
interface ifetch_icache_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  modport master(output memReq, memAddr, input memAck, memData);
  modport slave(input memReq, memAddr, output memAck, memData);
endinterface

// File: rtl/ifetch_icache.sv
// ifetch_icache: PC register plus direct-mapped instruction cache with in-order line refill.
module ifetch_icache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            stall,
  input  logic            pcSrc,
  input  logic [31:0]     branchTarget,
  output logic [31:0]     inst,
  output logic [31:0]     nextPC,
  output logic            hit,
  output logic [31:0]     pc,
  ifetch_icache_if.master mem
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - OB - IB;
  typedef enum logic {LOOKUP, REFILL} state_e;
  state_e          state_q;
  logic [31:0]     pc_q, pc_d, pend_target_q;
  logic            pend_q, mem_req_q, last_ack;
  logic [OB-1:0]   cnt_q;
  logic [LINES-1:0] valid_q;
  logic [TB-1:0]   tag_q [LINES];
  logic [31:0]     data_q [LINES*WORDS];
  logic [IB-1:0]   idx;
  logic [OB-1:0]   off;
  logic [TB-1:0]   tag;
  assign idx = pc_q[OB+IB+1:OB+2];
  assign off = pc_q[OB+1:2];
  assign tag = pc_q[31:OB+IB+2];
  assign hit = state_q == LOOKUP && valid_q[idx] && tag_q[idx] == tag;
  assign inst = data_q[{idx, off}];
  assign nextPC = pc_q + 32'd4;
  assign pc = pc_q;
  assign mem.memReq = mem_req_q;
  assign mem.memAddr = mem_req_q ? {pc_q[31:OB+2], cnt_q, 2'b00} : 32'h0;
  assign last_ack = state_q == REFILL && mem.memAck && cnt_q == OB'(WORDS - 1);
  // A redirect arriving on the final ack wins over an older pending one.
  always_comb begin
    pc_d = pc_q;
    if (state_q == LOOKUP && hit && !stall) pc_d = pcSrc ? branchTarget : nextPC;
    else if (last_ack) pc_d = pcSrc ? branchTarget : (pend_q ? pend_target_q : pc_q);
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= LOOKUP;
      pc_q <= RESET_PC;
      pend_q <= 1'b0;
      pend_target_q <= 32'h0;
      mem_req_q <= 1'b0;
      cnt_q <= '0;
      valid_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_q == LOOKUP) begin
        if (!hit) begin
          state_q <= REFILL;
          cnt_q <= '0;
          mem_req_q <= 1'b1;
          valid_q[idx] <= 1'b0;
        end
      end else begin
        if (pcSrc) begin
          pend_q <= 1'b1;
          pend_target_q <= branchTarget;
        end
        if (mem.memAck) cnt_q <= cnt_q + OB'(1);
        if (last_ack) begin
          valid_q[idx] <= 1'b1;
          mem_req_q <= 1'b0;
          pend_q <= 1'b0;
          state_q <= LOOKUP;
        end
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (state_q == REFILL && mem.memAck) data_q[{idx, cnt_q}] <= mem.memData;
    if (last_ack) tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_ifetch_icache.sv
// tb_ifetch_icache: vector table for hit/stall/redirect behaviour plus hand sequences for refill corners.
module tb_ifetch_icache;
  logic        Clk = 1'b0, Rst = 1'b0, stall = 1'b0, pcSrc = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic [31:0] inst, nextPC, pc;
  logic        hit;
  int          n_cmp = 0, n_bad = 0, mem_wait = 0, wcnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] sb [$];
  ifetch_icache_if m();
  ifetch_icache dut (
    .Clk(Clk), .Rst(Rst), .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
    .inst(inst), .nextPC(nextPC), .hit(hit), .pc(pc), .mem(m)
  );
  always #5 Clk = ~Clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + {2'b00, a[31:2]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic wait_hit(input string name, input int exp);
    int n = 0;
    while (!hit && n < exp + 20) begin
      step();
      n++;
    end
    chk(name, n, exp);
  endtask
  task automatic push_line(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
  endtask
  task automatic jump(input logic [31:0] t);
    pcSrc = 1'b1;
    branchTarget = t;
    step();
    pcSrc = 1'b0;
  endtask
  // Memory model: acks every request after mem_wait idle cycles and checks the address order.
  always @(negedge Clk) begin
    if (m.memReq) begin
      if (wcnt < mem_wait) begin
        wcnt++;
        m.memAck = 1'b0;
      end else begin
        wcnt = 0;
        m.memAck = 1'b1;
        m.memData = mem_word(m.memAddr);
        if (sb.size() == 0) chk("sb_underflow", m.memAddr, 32'hFFFF_FFFF);
        else chk("refill_addr", m.memAddr, sb.pop_front());
      end
    end else begin
      wcnt = 0;
      m.memAck = force_ack;
      m.memData = 32'hDEAD_BEEF;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  typedef struct {
    logic        stall, pcsrc;
    logic [31:0] tgt, pc;
    logic        hit;
    logic [31:0] inst, npc;
    logic        req;
  } vec_t;
  vec_t tbl [13];
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'hA0, 32'h4,  1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,  32'h4,  1'b1, 32'hA1, 32'h8,  1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  32'h8,  1'b1, 32'hA2, 32'hC,  1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,  32'h8,  1'b1, 32'hA2, 32'hC,  1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h40, 32'h8,  1'b1, 32'hA2, 32'hC,  1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'h8,  1'b1, 32'hA2, 32'hC,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h4,  32'hC,  1'b1, 32'hA3, 32'h10, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,  32'h4,  1'b1, 32'hA1, 32'h8,  1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'hA0, 32'h4,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  32'h4,  1'b1, 32'hA1, 32'h8,  1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  32'h8,  1'b1, 32'hA2, 32'hC,  1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  32'hC,  1'b1, 32'hA3, 32'h10, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  32'h10, 1'b0, 32'h0,  32'h14, 1'b0};
    #2 Rst = 1'b1;
    step();
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_req", 32'(m.memReq), 32'h0);
    chk("rst_addr", m.memAddr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    step();
    Rst = 1'b0;
    push_line(32'h0, 4);
    chk("miss0_hit", 32'(hit), 32'h0);
    step();
    chk("miss0_req", 32'(m.memReq), 32'h1);
    chk("miss0_addr", m.memAddr, 32'h0);
    wait_hit("miss0_latency", 4);
    push_line(32'h10, 4);
    mem_wait = 1;
    force_ack = 1'b1;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
      chk($sformatf("vec%0d_npc", i), nextPC, tbl[i].npc);
      chk($sformatf("vec%0d_req", i), 32'(m.memReq), 32'(tbl[i].req));
      if (tbl[i].hit) chk($sformatf("vec%0d_inst", i), inst, tbl[i].inst);
      stall = tbl[i].stall;
      pcSrc = tbl[i].pcsrc;
      branchTarget = tbl[i].tgt;
      step();
    end
    stall = 1'b0;
    pcSrc = 1'b0;
    force_ack = 1'b0;
    wait_hit("wait_latency", 8);
    chk("wait_inst", inst, 32'hA4);
    mem_wait = 0;
    jump(32'h40);
    chk("redir_miss", 32'(hit), 32'h0);
    push_line(32'h40, 4);
    step();
    chk("redir_addr0", m.memAddr, 32'h40);
    step();
    pcSrc = 1'b1;
    branchTarget = 32'h8;
    step();
    pcSrc = 1'b0;
    chk("redir_pc_hold", pc, 32'h40);
    chk("redir_addr2", m.memAddr, 32'h48);
    wait_hit("redir_latency", 2);
    chk("redir_pc", pc, 32'h8);
    chk("redir_inst", inst, 32'hA2);
    jump(32'h40);
    chk("redir_line_hit", 32'(hit), 32'h1);
    chk("redir_line_inst", inst, 32'hB0);
    jump(32'h100);
    push_line(32'h100, 4);
    chk("conf_miss1", 32'(hit), 32'h0);
    wait_hit("conf_latency1", 5);
    chk("conf_inst1", inst, 32'hE0);
    jump(32'h0);
    push_line(32'h0, 4);
    chk("conf_miss0", 32'(hit), 32'h0);
    step();
    chk("conf_addr0", m.memAddr, 32'h0);
    wait_hit("conf_latency0", 4);
    chk("conf_inst0", inst, 32'hA0);
    jump(32'h20);
    push_line(32'h20, 2);
    step();
    step();
    step();
    Rst = 1'b1;
    #1;
    chk("abort_req", 32'(m.memReq), 32'h0);
    chk("abort_hit", 32'(hit), 32'h0);
    chk("abort_pc", pc, 32'h0);
    step();
    Rst = 1'b0;
    push_line(32'h0, 4);
    chk("post_rst_miss", 32'(hit), 32'h0);
    wait_hit("post_rst_latency", 5);
    jump(32'h20);
    push_line(32'h20, 4);
    chk("refetch_miss", 32'(hit), 32'h0);
    step();
    chk("refetch_addr0", m.memAddr, 32'h20);
    wait_hit("refetch_latency", 4);
    chk("refetch_inst", inst, 32'hA8);
    jump(32'hFFFF_FFFC);
    push_line(32'hFFFF_FFF0, 4);
    chk("wrap_npc", nextPC, 32'h0);
    wait_hit("wrap_latency", 5);
    chk("wrap_inst", inst, 32'h4000_009F);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
